// File: rtl/lane_reorder_ctrl.sv
// RX lane-reorder sequencing controller: waits for AM lock on all lanes, releases deskew,
// enables reorder, holds aligned status, and retries through a hold-off on lock loss or timeout.
module lane_reorder_ctrl #(
  parameter int N_LANES        = 20,
  parameter int NB_TIMEOUT     = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int NB_RESYNC      = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [N_LANES-1:0]   i_am_lock,
  input  logic                 i_deskew_done,
  input  logic                 i_update_selectors,
  output logic                 o_deskew_enable,
  output logic                 o_reorder_enable,
  output logic                 o_reset_order,
  output logic                 o_align_status,
  output logic [2:0]           o_state,
  output logic [NB_RESYNC-1:0] o_resync_count
);

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_WAIT_DESKEW = 3'd2,
    ST_REORDER     = 3'd3,
    ST_ALIGNED     = 3'd4,
    ST_HOLDOFF     = 3'd5
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_TIMEOUT-1:0] HOLDOFF_LAST = NB_TIMEOUT'(HOLDOFF_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [NB_TIMEOUT-1:0]  timer_q, timer_d;
  logic                   entry_q, entry_d;
  logic                   deskew_en_q, deskew_en_d;
  logic                   reorder_en_q, reorder_en_d;
  logic                   reset_order_q, reset_order_d;
  logic                   align_q, align_d;
  logic [NB_RESYNC-1:0]   resync_q, resync_d;
  logic                   all_lock;
  logic                   adv;
  logic                   go_holdoff;

  assign all_lock = &i_am_lock;
  assign adv      = i_enable && i_valid;

  // Outputs are computed from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    entry_d       = entry_q;
    deskew_en_d   = deskew_en_q;
    reorder_en_d  = reorder_en_q;
    align_d       = align_q;
    resync_d      = resync_q;
    reset_order_d = 1'b0;
    go_holdoff    = 1'b0;
    if (i_enable) begin
      entry_d      = 1'b0;
      deskew_en_d  = 1'b0;
      reorder_en_d = 1'b0;
      align_d      = 1'b0;
      case (state_q)
        ST_INIT: begin
          reset_order_d = 1'b1;
          state_d       = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (all_lock && adv) state_d = ST_WAIT_DESKEW;
        end
        ST_WAIT_DESKEW: begin
          deskew_en_d = 1'b1;
          if (!all_lock) begin
            go_holdoff = 1'b1;
          end else if (i_deskew_done && adv) begin
            state_d = ST_REORDER;
            timer_d = '0;
          end
        end
        ST_REORDER: begin
          deskew_en_d  = 1'b1;
          reorder_en_d = 1'b1;
          if (adv) timer_d = timer_q + NB_TIMEOUT'(1);
          if (!all_lock)                         go_holdoff = 1'b1;
          else if (i_update_selectors)           state_d    = ST_ALIGNED;
          else if (adv && timer_q == TIMEOUT_LAST) go_holdoff = 1'b1;
        end
        ST_ALIGNED: begin
          deskew_en_d  = 1'b1;
          reorder_en_d = 1'b1;
          align_d      = 1'b1;
          if (!all_lock || !i_deskew_done) go_holdoff = 1'b1;
        end
        ST_HOLDOFF: begin
          if (entry_q) begin
            reset_order_d = 1'b1;
            if (resync_q != '1) resync_d = resync_q + NB_RESYNC'(1);
          end
          if (adv) begin
            if (timer_q == HOLDOFF_LAST) state_d = ST_WAIT_LOCK;
            else                         timer_d = timer_q + NB_TIMEOUT'(1);
          end
        end
        default: state_d = ST_INIT;
      endcase
      // entry_q marks the first HOLDOFF cycle, where the order-reset pulse and retry count fire.
      if (go_holdoff) begin
        state_d = ST_HOLDOFF;
        timer_d = '0;
        entry_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= ST_INIT;
      timer_q       <= '0;
      entry_q       <= 1'b0;
      deskew_en_q   <= 1'b0;
      reorder_en_q  <= 1'b0;
      reset_order_q <= 1'b0;
      align_q       <= 1'b0;
      resync_q      <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      entry_q       <= entry_d;
      deskew_en_q   <= deskew_en_d;
      reorder_en_q  <= reorder_en_d;
      reset_order_q <= reset_order_d;
      align_q       <= align_d;
      resync_q      <= resync_d;
    end
  end

  assign o_deskew_enable  = deskew_en_q;
  assign o_reorder_enable = reorder_en_q;
  assign o_reset_order    = reset_order_q;
  assign o_align_status   = align_q;
  assign o_state          = state_q;
  assign o_resync_count   = resync_q;

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// Directed bench for lane_reorder_ctrl: a vector table for the bring-up path, then
// hand-written sequences for timeout, lock loss, priority, valid gating, saturation and reset.
module tb_lane_reorder_ctrl;

  localparam int NL = 20;
  localparam logic [NL-1:0] LOCK_ALL = '1;

  logic          clk = 1'b0;
  logic          rst, en, val, dsk, upd;
  logic [NL-1:0] lock;
  logic          de_o, re_o, ro_o, al_o;
  logic [2:0]    st_o;
  logic [7:0]    cnt_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          rst, en, val;
    logic [NL-1:0] lock;
    logic          dsk, upd;
    logic [2:0]    st;
    logic          ro, de, re, al;
  } vec_t;

  vec_t vecs[$];

  lane_reorder_ctrl dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_enable           (en),
    .i_valid            (val),
    .i_am_lock          (lock),
    .i_deskew_done      (dsk),
    .i_update_selectors (upd),
    .o_deskew_enable    (de_o),
    .o_reorder_enable   (re_o),
    .o_reset_order      (ro_o),
    .o_align_status     (al_o),
    .o_state            (st_o),
    .o_resync_count     (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic e, input logic v, input logic [NL-1:0] l,
                         input logic d, input logic u, input logic [2:0] s,
                         input logic o, input logic de, input logic re, input logic a);
    vec_t x;
    x.rst = r; x.en = e; x.val = v; x.lock = l; x.dsk = d; x.upd = u;
    x.st = s; x.ro = o; x.de = de; x.re = re; x.al = a;
    vecs.push_back(x);
  endtask

  // From WAIT_LOCK: lock and deskew-done present, two edges land in REORDER with the timer cleared.
  task automatic go_reorder();
    en = 1; val = 1; lock = LOCK_ALL; dsk = 1; upd = 0;
    step(); chk("go_wd_state", st_o, 2);
    step(); chk("go_reorder_state", st_o, 3);
  endtask

  // Called right after the edge that entered HOLDOFF; 16 valid cycles then WAIT_LOCK.
  task automatic holdoff_check(input int exp_cnt);
    en = 1; val = 1; upd = 0; lock = LOCK_ALL;
    step();
    chk("ho_first_state", st_o, 5);
    chk("ho_reset_order", ro_o, 1);
    chk("ho_resync", cnt_o, exp_cnt);
    chk("ho_align", al_o, 0);
    chk("ho_deskew_en", de_o, 0);
    chk("ho_reorder_en", re_o, 0);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("ho_mid_state", st_o, 5);
      chk("ho_mid_reset_order", ro_o, 0);
    end
    step();
    chk("ho_exit_state", st_o, 1);
  endtask

  initial begin
    int exp_cnt;
    rst = 1; en = 1; val = 1; lock = '0; dsk = 0; upd = 0;

    // Bring-up path: reset, INIT, WAIT_LOCK, WAIT_DESKEW, REORDER, ALIGNED.
    add_vec(1, 1, 1, '0,       0, 0, 3'd0, 0, 0, 0, 0);
    add_vec(1, 1, 1, '0,       0, 0, 3'd0, 0, 0, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 0, 0, 3'd1, 1, 0, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 0, 0, 3'd2, 0, 0, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 0, 0, 3'd2, 0, 1, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 0, 0, 3'd2, 0, 1, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 0, 0, 3'd2, 0, 1, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 1, 1, 3'd3, 0, 1, 0, 0);
    add_vec(0, 1, 1, LOCK_ALL, 1, 0, 3'd3, 0, 1, 1, 0);
    for (int i = 0; i < 30; i++) add_vec(0, 1, 1, LOCK_ALL, 1, 0, 3'd3, 0, 1, 1, 0);
    add_vec(0, 1, 0, LOCK_ALL, 1, 1, 3'd4, 0, 1, 1, 0);
    add_vec(0, 1, 1, LOCK_ALL, 1, 0, 3'd4, 0, 1, 1, 1);
    add_vec(0, 1, 1, LOCK_ALL, 1, 0, 3'd4, 0, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; val = vecs[i].val;
      lock = vecs[i].lock; dsk = vecs[i].dsk; upd = vecs[i].upd;
      step();
      chk($sformatf("vec%0d_state", i), st_o, vecs[i].st);
      chk($sformatf("vec%0d_reset_order", i), ro_o, vecs[i].ro);
      chk($sformatf("vec%0d_deskew_en", i), de_o, vecs[i].de);
      chk($sformatf("vec%0d_reorder_en", i), re_o, vecs[i].re);
      chk($sformatf("vec%0d_align", i), al_o, vecs[i].al);
    end
    chk("bringup_resync", cnt_o, 0);

    // Lane 7 drops for one cycle while aligned.
    lock = LOCK_ALL; lock[7] = 1'b0;
    step();
    chk("lane7_state", st_o, 5);
    chk("lane7_align_still_high", al_o, 1);
    holdoff_check(1);

    // Reorder timeout after 200 valid cycles.
    go_reorder();
    dsk = 0;
    for (int i = 0; i < 199; i++) begin
      step();
      chk("timeout_wait_state", st_o, 3);
    end
    step();
    chk("timeout_state", st_o, 5);
    holdoff_check(2);

    // Spurious update pulse outside REORDER.
    lock = '0; upd = 1;
    step();
    chk("spurious_upd_state", st_o, 1);
    chk("spurious_upd_align", al_o, 0);
    upd = 0;

    // Lock loss beats update pulse.
    go_reorder();
    lock = LOCK_ALL; lock[3] = 1'b0; upd = 1;
    step();
    chk("lockloss_vs_upd_state", st_o, 5);
    holdoff_check(3);

    // Update pulse beats timeout on the same cycle; then deskew loss leaves ALIGNED.
    go_reorder();
    for (int i = 0; i < 199; i++) step();
    chk("pre_timeout_state", st_o, 3);
    upd = 1;
    step();
    chk("upd_vs_timeout_state", st_o, 4);
    upd = 0;
    step();
    chk("upd_vs_timeout_align", al_o, 1);
    dsk = 0;
    step();
    chk("deskew_loss_state", st_o, 5);
    holdoff_check(4);

    // HOLDOFF with i_valid toggling and a 10-cycle enable freeze.
    go_reorder();
    lock = '0;
    step();
    chk("t5_enter_state", st_o, 5);
    lock = LOCK_ALL;
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        en = 0; val = 1;
        for (int k = 0; k < 10; k++) begin
          step();
          chk("freeze_state", st_o, 5);
          chk("freeze_reset_order", ro_o, 0);
          chk("freeze_resync", cnt_o, 5);
        end
        en = 1;
      end
      val = (i % 2 == 1);
      step();
      if (i == 0) begin
        chk("t5_reset_order", ro_o, 1);
        chk("t5_resync", cnt_o, 5);
      end
      chk($sformatf("t5_state_i%0d", i), st_o, (i == 31) ? 1 : 5);
    end
    val = 1;

    // 300 fast retries: WAIT_LOCK -> WAIT_DESKEW -> lock loss -> HOLDOFF.
    exp_cnt = 5;
    for (int r = 0; r < 300; r++) begin
      lock = LOCK_ALL;
      step();
      lock = '0;
      step();
      for (int k = 0; k < 16; k++) step();
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("retry_state", st_o, 1);
      chk("retry_resync", cnt_o, exp_cnt);
    end
    chk("resync_saturated", cnt_o, 255);

    // Reset mid-REORDER.
    go_reorder();
    step(); step(); step();
    rst = 1;
    step();
    chk("rst_state", st_o, 0);
    chk("rst_deskew_en", de_o, 0);
    chk("rst_reorder_en", re_o, 0);
    chk("rst_reset_order", ro_o, 0);
    chk("rst_align", al_o, 0);
    chk("rst_resync", cnt_o, 0);
    rst = 0;
    step();
    chk("post_rst_state", st_o, 1);
    chk("post_rst_reset_order", ro_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lane_reorder_ctrl.md
Name: lane_reorder_ctrl

Overview:
Sequencing controller for the RX lane-reorder stage of the 100GbE PCS. It waits for alignment-marker lock on all PCS lanes, then releases deskew and enables the reorder block. It confirms completion through the reorder block's update pulse and holds aligned status. On lock loss or reorder timeout it clears the reorder and deskew state and retries after a hold-off. It sits between the per-lane AM-lock logic, the deskew block and the lane reorder block, and drives their enables and order-reset.

Parameters:
N_LANES, 20, number of PCS lanes.
NB_TIMEOUT, 8, width of the reorder timeout counter.
TIMEOUT_CYCLES, 200, valid cycles allowed in REORDER before a retry; must be less than 2**NB_TIMEOUT.
HOLDOFF_CYCLES, 16, valid cycles spent in HOLDOFF before WAIT_LOCK; must be less than 2**NB_TIMEOUT.
NB_RESYNC, 8, width of the saturating resync counter.

Ports:
i_clock  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_enable  in  1  global block enable; when low, state and all counters are frozen.
i_valid  in  1  datapath valid strobe; counters advance only on cycles where i_enable && i_valid.
i_am_lock  in  N_LANES  per-lane alignment-marker lock; bit k is lane k.
i_deskew_done  in  1  deskew block reports lanes aligned.
i_update_selectors  in  1  single-cycle pulse from the reorder block: selectors valid, all IDs present.
o_deskew_enable  out  1  enables the deskew block.
o_reorder_enable  out  1  drives the reorder block's i_enable.
o_reset_order  out  1  one-cycle pulse that clears the reorder and deskew state.
o_align_status  out  1  PCS alignment status.
o_state  out  3  current state encoding, for debug.
o_resync_count  out  NB_RESYNC  number of retries, saturating.

Behaviour:
- State encoding: INIT=0, WAIT_LOCK=1, WAIT_DESKEW=2, REORDER=3, ALIGNED=4, HOLDOFF=5. Any other encoding goes to INIT on the next cycle.
- Define all_lock = &i_am_lock and adv = i_enable && i_valid.
- Reset values: state=INIT, o_deskew_enable=0, o_reorder_enable=0, o_reset_order=0, o_align_status=0, o_resync_count=0, timer=0.
- All outputs are registered. Each output reflects the state one cycle after the state changes.
- When i_enable=0: state, timer and o_resync_count hold; o_reset_order is forced to 0; all other outputs hold.
- INIT:
  - Pulse o_reset_order for 1 cycle.
  - Next cycle go to WAIT_LOCK. This happens unconditionally when i_enable=1.
- WAIT_LOCK:
  - Deskew and reorder enables are 0.
  - If all_lock=1 on a cycle with adv=1, go to WAIT_DESKEW.
- WAIT_DESKEW:
  - o_deskew_enable=1.
  - If all_lock=0 (on any cycle with i_enable=1), go to HOLDOFF.
  - Otherwise, if i_deskew_done=1 with adv=1, go to REORDER and clear the timer.
- REORDER:
  - o_deskew_enable=1 and o_reorder_enable=1.
  - The timer increments on each adv cycle.
  - Priority, highest first:
    1. all_lock=0 goes to HOLDOFF.
    2. i_update_selectors=1 goes to ALIGNED. The pulse is accepted regardless of i_valid.
    3. timer reaching TIMEOUT_CYCLES-1 on an adv cycle goes to HOLDOFF.
- ALIGNED:
  - o_align_status=1; both enables stay 1.
  - If all_lock=0 or i_deskew_done=0, go to HOLDOFF.
  - o_align_status falls in the cycle after that condition is sampled.
- HOLDOFF:
  - Entry cycle:
    - o_reset_order pulses for exactly 1 cycle.
    - o_resync_count increments, saturating at all ones.
    - The timer clears.
  - Both enables are 0 and o_align_status=0 throughout.
  - The timer counts adv cycles. At HOLDOFF_CYCLES-1 on an adv cycle, go to WAIT_LOCK.
  - all_lock is ignored while in HOLDOFF.
- Simultaneous events:
  - Lock loss beats both the update pulse and the timeout.
  - The update pulse beats the timeout on the same cycle.
- i_reset asserted in any state, including mid-REORDER, returns to the reset values next cycle. No o_reset_order pulse is emitted until INIT is executed after reset deasserts.
- A spurious i_update_selectors outside REORDER is ignored.
- Timer width is NB_TIMEOUT. It is compared against the parameter constant and never wraps inside a state, because the timeout constants are below 2**NB_TIMEOUT.

Test Plan:
1. Reset, then i_am_lock=all ones, i_valid=1, i_deskew_done asserted 5 cycles later, then i_update_selectors pulsed 30 cycles later -> states visit 0,1,2,3,4. o_reset_order pulses once, after INIT. o_align_status=1 one cycle after entering ALIGNED. o_resync_count=0.
2. In REORDER with no update pulse for 200 valid cycles -> HOLDOFF, o_reset_order pulses 1 cycle, o_resync_count=1. After 16 valid cycles, state=WAIT_LOCK.
3. In ALIGNED, drop i_am_lock[7] for 1 cycle -> o_align_status=0 two cycles later. HOLDOFF is entered and o_resync_count increments.
4. In REORDER, i_update_selectors and lane-lock loss on the same cycle -> HOLDOFF, not ALIGNED.
5. i_valid toggling 1/0 in HOLDOFF -> WAIT_LOCK is reached after exactly 16 valid cycles (32 clocks). Hold i_enable=0 mid-HOLDOFF for 10 cycles -> timer and state frozen.
6. Force 300 retries -> o_resync_count saturates at 255. Assert i_reset mid-REORDER -> all outputs return to their reset values next cycle.
